// File: rtl/axis_frame_guard.sv
// AXI-stream frame length guard: marks runt frames bad, truncates oversize frames and drops tails.
// Optional per-class frame counters are enabled by defining FRAME_GUARD_STATS_EN.
module axis_frame_guard #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned MIN_LEN    = 60,
  parameter int unsigned MAX_LEN    = 1518,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,

  output logic                  status_good,
  output logic                  status_runt,
  output logic                  status_oversize
`ifdef FRAME_GUARD_STATS_EN
  ,
  output logic [31:0]           stat_good_cnt,
  output logic [31:0]           stat_runt_cnt,
  output logic [31:0]           stat_oversize_cnt
`endif
);

  localparam logic [LEN_WIDTH-1:0] MinLen = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] MaxLen = LEN_WIDTH'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StActive, StDiscard} state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_len, len_next;

  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [KEEP_WIDTH-1:0] m_keep_q;
  logic                  m_last_q;
  logic [USER_WIDTH-1:0] m_user_q;

  logic                  good_q, runt_q, over_q;
  logic                  good_d, runt_d, over_d;

  logic                  s_ready;
  logic                  accept;
  logic                  load;
  logic                  out_last;
  logic [USER_WIDTH-1:0] out_user;

  function automatic logic [LEN_WIDTH-1:0] popcount(input logic [KEEP_WIDTH-1:0] keep);
    logic [LEN_WIDTH-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
      cnt = cnt + LEN_WIDTH'(keep[i]);
    end
    return cnt;
  endfunction

  // Discarded tail beats never reach the output register, so they need no downstream space.
  assign s_ready       = (state_q == StDiscard) || !m_valid_q || m_axis_tready;
  assign s_axis_tready = !rst && s_ready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign beat_len = popcount(s_axis_tkeep);
  assign len_next = len_q + beat_len;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    load     = 1'b0;
    out_last = s_axis_tlast;
    out_user = s_axis_tuser;
    good_d   = 1'b0;
    runt_d   = 1'b0;
    over_d   = 1'b0;

    if (accept) begin
      case (state_q)
        StIdle, StActive: begin
          load = 1'b1;
          if (len_next > MaxLen) begin
            // Oversize wins over runt/good even on the frame's own last beat.
            out_last    = 1'b1;
            out_user[0] = 1'b1;
            over_d      = 1'b1;
            len_d       = '0;
            state_d     = s_axis_tlast ? StIdle : StDiscard;
          end else if (s_axis_tlast) begin
            len_d   = '0;
            state_d = StIdle;
            if (len_next < MinLen) begin
              out_user[0] = 1'b1;
              runt_d      = 1'b1;
            end else begin
              good_d = 1'b1;
            end
          end else begin
            len_d   = len_next;
            state_d = StActive;
          end
        end
        StDiscard: begin
          if (s_axis_tlast) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      len_q     <= '0;
      m_valid_q <= 1'b0;
      good_q    <= 1'b0;
      runt_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      good_q  <= good_d;
      runt_q  <= runt_d;
      over_q  <= over_d;
      if (load) begin
        m_valid_q <= 1'b1;
      end else if (m_axis_tready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  // Payload needs no reset: it is qualified by m_valid_q.
  always_ff @(posedge clk) begin
    if (load) begin
      m_data_q <= s_axis_tdata;
      m_keep_q <= s_axis_tkeep;
      m_last_q <= out_last;
      m_user_q <= out_user;
    end
  end

  assign m_axis_tvalid   = m_valid_q;
  assign m_axis_tdata    = m_data_q;
  assign m_axis_tkeep    = m_keep_q;
  assign m_axis_tlast    = m_last_q;
  assign m_axis_tuser    = m_user_q;

  assign status_good     = good_q;
  assign status_runt     = runt_q;
  assign status_oversize = over_q;

`ifdef FRAME_GUARD_STATS_EN
  logic [31:0] good_cnt_q, runt_cnt_q, over_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      good_cnt_q <= '0;
      runt_cnt_q <= '0;
      over_cnt_q <= '0;
    end else begin
      if (good_q) good_cnt_q <= good_cnt_q + 32'd1;
      if (runt_q) runt_cnt_q <= runt_cnt_q + 32'd1;
      if (over_q) over_cnt_q <= over_cnt_q + 32'd1;
    end
  end

  assign stat_good_cnt     = good_cnt_q;
  assign stat_runt_cnt     = runt_cnt_q;
  assign stat_oversize_cnt = over_cnt_q;
`endif

endmodule

// File: tb/tb_axis_frame_guard.sv
// Randomized self-checking bench for axis_frame_guard against a frame-level reference model.
module tb_axis_frame_guard;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int UW = 2;
  localparam int MINL = 60;
  localparam int MAXL = 1518;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [UW-1:0] m_axis_tuser;
  logic          status_good, status_runt, status_oversize;
`ifdef FRAME_GUARD_STATS_EN
  logic [31:0]   stat_good_cnt, stat_runt_cnt, stat_oversize_cnt;
`endif

  axis_frame_guard #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
    .MIN_LEN(MINL), .MAX_LEN(MAXL), .LEN_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .status_good(status_good), .status_runt(status_runt), .status_oversize(status_oversize)
`ifdef FRAME_GUARD_STATS_EN
    ,
    .stat_good_cnt(stat_good_cnt), .stat_runt_cnt(stat_runt_cnt),
    .stat_oversize_cnt(stat_oversize_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;  // 0: always ready, 1: random 50%, 2: left to the test
  int stall_err = 0;
  int n_good = 0, n_runt = 0, n_over = 0;

  beat_t frame_q[$];
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    st_exp[$];  // 1 good, 2 runt, 3 oversize
  int    st_obs[$];
  int    acc_cyc[$];
  int    out_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) m_axis_tready = 1'b1;
      else if (ready_mode == 1) m_axis_tready = 1'($urandom % 2);
    end
  end

  // Monitor: a handshake seen at the negedge completes on the next posedge.
  beat_t prev_beat;
  bit    prev_stall = 1'b0;
  always @(negedge clk) begin
    beat_t cur;
    cur = '{data: m_axis_tdata, keep: m_axis_tkeep, last: m_axis_tlast, user: m_axis_tuser};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_axis_tvalid || cur !== prev_beat)) stall_err++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = cur;
      if (m_axis_tvalid && m_axis_tready) begin
        obs_q.push_back(cur);
        out_cyc.push_back(cyc);
      end
      if (status_good) st_obs.push_back(1);
      if (status_runt) st_obs.push_back(2);
      if (status_oversize) st_obs.push_back(3);
    end
  end

  // Reference: walk the frame's cumulative byte count and apply the length rules.
  task automatic model_frame();
    int sum = 0;
    foreach (frame_q[i]) begin
      beat_t e;
      e = frame_q[i];
      sum += $countones(frame_q[i].keep);
      if (sum > MAXL) begin
        e.last = 1'b1; e.user[0] = 1'b1;
        exp_q.push_back(e); st_exp.push_back(3); n_over++;
        return;
      end
      if (frame_q[i].last) begin
        if (sum < MINL) begin
          e.user[0] = 1'b1; st_exp.push_back(2); n_runt++;
        end else begin
          st_exp.push_back(1); n_good++;
        end
        exp_q.push_back(e);
        return;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic build_len_frame(input int len);
    int nb = (len + 7) / 8;
    frame_q.delete();
    for (int i = 0; i < nb; i++) begin
      beat_t b;
      logic [KW-1:0] k;
      k = '1;
      if (i == nb - 1 && (len % 8) != 0) k = KW'((9'd1 << (len % 8)) - 9'd1);
      b.data = {$urandom, $urandom};
      b.keep = k;
      b.last = (i == nb - 1);
      b.user = {1'($urandom), 1'b0};
      frame_q.push_back(b);
    end
  endtask

  task automatic drive_beat(input beat_t b);
    bit acc = 1'b0;
    s_axis_tdata = b.data; s_axis_tkeep = b.keep; s_axis_tlast = b.last;
    s_axis_tuser = b.user; s_axis_tvalid = 1'b1;
    for (int n = 0; n < 2000 && !acc; n++) begin
      @(negedge clk);
      acc = s_axis_tready;
      if (acc) acc_cyc.push_back(cyc);
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: s_axis_tready stayed 0, required 1");
    end
  endtask

  task automatic send_frame(input bit gaps);
    model_frame();
    foreach (frame_q[i]) begin
      drive_beat(frame_q[i]);
      if (gaps && ($urandom % 4 == 0)) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic clear_all();
    exp_q.delete(); obs_q.delete(); st_exp.delete(); st_obs.delete();
    acc_cyc.delete(); out_cyc.delete();
  endtask

  task automatic check_outputs(input string name);
    int w = 0;
    while ((obs_q.size() < exp_q.size() || st_obs.size() < st_exp.size()) && w < 20000) begin
      @(posedge clk); w++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s beat_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i >= obs_q.size()) break;
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s beat %0d: got keep=%h last=%b user=%b data=%h required keep=%h last=%b user=%b data=%h",
                 name, i, obs_q[i].keep, obs_q[i].last, obs_q[i].user, obs_q[i].data,
                 exp_q[i].keep, exp_q[i].last, exp_q[i].user, exp_q[i].data);
        break;
      end
    end
    checks++;
    if (st_obs !== st_exp) begin
      errors++;
      $display("FAIL %s status: got %0d pulses (first %0d) required %0d pulses (first %0d)",
               name, st_obs.size(), (st_obs.size() > 0) ? st_obs[0] : 0,
               st_exp.size(), (st_exp.size() > 0) ? st_exp[0] : 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: m_tvalid=%b s_tready=%b required 0 0", m_axis_tvalid, s_axis_tready);
    end
    checks++;
    if ({status_good, status_runt, status_oversize} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: got %b required 000", {status_good, status_runt, status_oversize});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", s_axis_tready);
    end
  endtask

  task automatic test_good64();
    clear_all();
    build_len_frame(64);
    foreach (frame_q[i]) frame_q[i].user = 2'b00;
    send_frame(1'b0);
    check_outputs("good64");
    foreach (out_cyc[i]) begin
      if (i >= acc_cyc.size()) break;
      checks++;
      if (out_cyc[i] !== acc_cyc[i] + 1) begin
        errors++;
        $display("FAIL good64_latency beat %0d: out cycle %0d required %0d", i, out_cyc[i], acc_cyc[i] + 1);
      end
    end
  endtask

  task automatic test_runt40();
    clear_all();
    build_len_frame(40);
    send_frame(1'b0);
    check_outputs("runt40");
  endtask

  task automatic test_oversize();
    clear_all();
    build_len_frame(1600);
    model_frame();
    for (int i = 0; i < 190; i++) drive_beat(frame_q[i]);
    // Stall downstream: tail beats must still be swallowed one per cycle.
    ready_mode = 2;
    m_axis_tready = 1'b0;
    for (int i = 190; i < 200; i++) drive_beat(frame_q[i]);
    s_axis_tvalid = 1'b0;
    checks++;
    if (acc_cyc.size() != 200 || acc_cyc[199] - acc_cyc[190] != 9) begin
      errors++;
      $display("FAIL oversize_discard_rate: accepted %0d beats, tail span %0d required 200 and 9",
               acc_cyc.size(), (acc_cyc.size() == 200) ? acc_cyc[199] - acc_cyc[190] : -1);
    end
    ready_mode = 0;
    check_outputs("oversize1600");
    clear_all();
    build_len_frame(64);
    send_frame(1'b0);
    check_outputs("after_oversize");
  endtask

  task automatic test_boundaries();
    int lens[4] = '{1518, 59, 60, 1519};
    foreach (lens[i]) begin
      clear_all();
      build_len_frame(lens[i]);
      send_frame(1'b0);
      check_outputs($sformatf("boundary_%0d", lens[i]));
    end
  endtask

  task automatic test_random_mixed();
    clear_all();
    ready_mode = 1;
    stall_err = 0;
    for (int f = 0; f < 100; f++) begin
      int nb;
      int sel = $urandom % 4;
      if (sel == 0) nb = $urandom_range(1, 10);
      else if (sel == 1) nb = $urandom_range(185, 200);
      else nb = $urandom_range(1, 200);
      frame_q.delete();
      for (int i = 0; i < nb; i++) begin
        beat_t b;
        b.data = {$urandom, $urandom};
        b.keep = ($urandom % 4 != 0) ? 8'hFF : 8'($urandom);
        b.last = (i == nb - 1);
        b.user = 2'($urandom);
        if ($urandom % 8 != 0) b.user[0] = 1'b0;
        frame_q.push_back(b);
      end
      send_frame(1'b1);
    end
    check_outputs("random_mixed");
    ready_mode = 0;
    checks++;
    if (stall_err !== 0) begin
      errors++;
      $display("FAIL stall_stability: %0d changes while stalled, required 0", stall_err);
    end
  endtask

  task automatic test_reset_midframe();
    clear_all();
    build_len_frame(64);
    drive_beat(frame_q[0]);
    drive_beat(frame_q[1]);
    s_axis_tdata = frame_q[2].data; s_axis_tkeep = frame_q[2].keep;
    s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ready: got %b required 0", s_axis_tready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_tvalid: got %b required 0", m_axis_tvalid);
    end
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    clear_all();
    // A leftover count from the abandoned frame would push 1512 bytes over the limit.
    build_len_frame(1512);
    send_frame(1'b0);
    build_len_frame(64);
    send_frame(1'b0);
    check_outputs("after_midreset");
  endtask

  initial begin
    test_reset();
`ifdef FRAME_GUARD_STATS_EN
    n_good = 0; n_runt = 0; n_over = 0;
`endif
    test_good64();
    test_runt40();
    test_oversize();
    test_boundaries();
    test_random_mixed();
`ifdef FRAME_GUARD_STATS_EN
    checks++;
    if (stat_good_cnt !== 32'(n_good) || stat_runt_cnt !== 32'(n_runt) ||
        stat_oversize_cnt !== 32'(n_over)) begin
      errors++;
      $display("FAIL stat_counters: got %0d/%0d/%0d required %0d/%0d/%0d", stat_good_cnt,
               stat_runt_cnt, stat_oversize_cnt, n_good, n_runt, n_over);
    end
`endif
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_frame_guard.md
# axis_frame_guard

Frame length guard placed directly upstream of the FIFO on each ingress path. Counts bytes per AXI-stream frame from tkeep and marks runt frames bad on their last beat. Truncates oversize frames at the beat that crosses the limit, forcing tlast and the bad marker, then silently discards the rest of the input frame. The downstream FIFO in frame mode with bad-frame dropping (mask/value bit 0) removes marked frames.

## Interface
- DATA_WIDTH, default 64: tdata width in bits.
- KEEP_WIDTH, default DATA_WIDTH/8: tkeep width, one bit per byte.
- USER_WIDTH, default 1: tuser width. Bit 0 is the bad-frame marker.
- MIN_LEN, default 60: minimum legal frame length in bytes.
- MAX_LEN, default 1518: maximum legal frame length in bytes. Must be ≥ MIN_LEN.
- LEN_WIDTH, default 16: byte counter width. Must satisfy 2**LEN_WIDTH > MAX_LEN + KEEP_WIDTH.
- clk  in  1: clock. Single clock domain.
- rst  in  1: synchronous, active-high reset.
- s_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  DATA_WIDTH/KEEP_WIDTH/1/1/1/USER_WIDTH: input stream.
- m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  same widths: output stream.
- status_good  out  1: one-cycle pulse, good frame completed.
- status_runt  out  1: one-cycle pulse, runt frame marked.
- status_oversize  out  1: one-cycle pulse, oversize frame truncated.

## Operation
- beat_len is the popcount of s_axis_tkeep (0..KEEP_WIDTH); a tkeep=0 beat counts 0. len_next = len_reg + beat_len.
- States are IDLE (no frame open), ACTIVE (mid-frame) and DISCARD (dropping the tail of a truncated frame).
- On an accepted beat in IDLE or ACTIVE, len_next is evaluated first for oversize:
  - Oversize (len_next > MAX_LEN): forward the beat with tlast=1 and tuser[0]=1. Pulse status_oversize. Go to DISCARD if s_tlast=0, else IDLE. Oversize takes priority over runt.
  - Runt (s_tlast=1, len_next < MIN_LEN): forward the beat with tuser[0]=1. Pulse status_runt. Go to IDLE.
  - Good (s_tlast=1, MIN_LEN ≤ len_next ≤ MAX_LEN): forward tuser unchanged. Pulse status_good. Go to IDLE.
  - Otherwise: forward the beat unchanged, len_reg ← len_next, go to ACTIVE.
- tuser bits other than bit 0 always pass through. An input tuser[0]=1 on any beat propagates unchanged and is not cleared.
- In DISCARD: s_axis_tready=1 and no output. On an accepted beat with s_tlast=1, go to IDLE. No status pulse.
- len_reg clears on every frame end (IDLE entry). Frame lengths exactly MIN_LEN or MAX_LEN are good.

## Timing
- Single output register stage: latency of 1 cycle from input acceptance to m_axis_tvalid.
- s_axis_tready = DISCARD || !m_axis_tvalid || m_axis_tready. Full throughput with no bubbles under continuous ready.
- Output holds tdata, tkeep, tlast and tuser stable while m_axis_tvalid=1 and m_axis_tready=0.
- Status pulses assert the cycle after the qualifying input beat is accepted.
- Reset values: m_axis_tvalid=0, s_axis_tready=0 during rst, all status outputs 0, state=IDLE, len_reg=0.
- Reset mid-frame abandons the partial frame with no forced tlast; the downstream stage is reset together.

## Configuration
- FRAME_GUARD_STATS_EN defined:
  - Adds output ports stat_good_cnt, stat_runt_cnt and stat_oversize_cnt, each 32 bits.
  - Each counter increments on its status pulse and wraps at 2^32.
  - Counters clear on rst.
- FRAME_GUARD_STATS_EN not defined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- All cases use DATA_WIDTH=64, MIN_LEN=60, MAX_LEN=1518.
- 64-byte frame, 8 beats with tkeep=0xFF, m_tready=1 → 8 output beats one cycle delayed, last beat tuser=0, one status_good pulse.
- 40-byte frame, 5 beats → 5 output beats, beat 5 tlast=1 and tuser[0]=1, one status_runt pulse.
- 1600-byte frame, 200 beats → 190 output beats (190×8=1520 > 1518), beat 190 forced tlast=1 and tuser[0]=1. Input beats 191–200 accepted with s_tready=1 and no output. One status_oversize pulse. Next frame passes normally.
- 1518-byte frame, 189 beats of 0xFF plus a last beat with tkeep=0x3F → good. 59-byte frame → runt. 60-byte frame → good.
- Random m_axis_tready at 50% over 100 mixed frames → output matches the reference model in order, with no loss or duplication, and output is stable while stalled.
- rst asserted at beat 3 of a 64-byte frame → m_axis_tvalid=0 the next cycle. A following 64-byte frame is counted from zero and passes good.
